// File: rtl/ariane_axi_sram_slv.sv
// AXI4 subordinate that turns bursts into single-port 64-bit SRAM accesses, one transaction at a
// time. Define ARIANE_AXI_SRAM_SLV_WRAP_EN to support WRAP bursts; otherwise they answer SLVERR.

package ariane_axi;
   localparam int unsigned IdWidthSlave = 5;
   typedef logic [IdWidthSlave-1:0] id_slv_t;

   typedef struct packed {
      id_slv_t     id;
      logic [63:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic        lock;
      logic [3:0]  cache;
      logic [2:0]  prot;
      logic [3:0]  qos;
      logic [3:0]  region;
      logic [5:0]  atop;
      logic        user;
   } aw_chan_slv_t;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  strb;
      logic        last;
      logic        user;
   } w_chan_t;

   typedef struct packed {
      id_slv_t    id;
      logic [1:0] resp;
      logic       user;
   } b_chan_slv_t;

   typedef struct packed {
      id_slv_t     id;
      logic [63:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic        lock;
      logic [3:0]  cache;
      logic [2:0]  prot;
      logic [3:0]  qos;
      logic [3:0]  region;
      logic        user;
   } ar_chan_slv_t;

   typedef struct packed {
      id_slv_t     id;
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
      logic        user;
   } r_chan_slv_t;

   typedef struct packed {
      aw_chan_slv_t aw;
      logic         aw_valid;
      w_chan_t      w;
      logic         w_valid;
      logic         b_ready;
      ar_chan_slv_t ar;
      logic         ar_valid;
      logic         r_ready;
   } req_slv_t;

   typedef struct packed {
      logic        aw_ready;
      logic        ar_ready;
      logic        w_ready;
      logic        b_valid;
      b_chan_slv_t b;
      logic        r_valid;
      r_chan_slv_t r;
   } resp_slv_t;
endpackage

module ariane_axi_sram_slv #(
   parameter int unsigned MemAddrWidth = 14
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  ariane_axi::req_slv_t    axi_req_i,
   output ariane_axi::resp_slv_t   axi_resp_o,
   output logic                    mem_req_o,
   output logic                    mem_we_o,
   output logic [MemAddrWidth-1:0] mem_addr_o,
   output logic [63:0]             mem_wdata_o,
   output logic [7:0]              mem_be_o,
   input  logic [63:0]             mem_rdata_i
);
   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlvErr = 2'b10;
   localparam logic [1:0] RespDecErr = 2'b11;
   localparam logic [1:0] BurstIncr  = 2'b01;
   localparam logic [1:0] BurstWrap  = 2'b10;

   typedef enum logic [2:0] {StIdle, StWrData, StWrResp, StRdMem, StRdResp} state_e;

   state_e              state_q, state_d;
   logic                prefer_rd_q, prefer_rd_d;
   ariane_axi::id_slv_t id_q, id_d;
   logic [63:0]         addr_q, addr_d;
   logic [7:0]          len_q, len_d, cnt_q, cnt_d;
   logic [2:0]          size_q, size_d;
   logic [1:0]          burst_q, burst_d, err_q, err_d;
   logic [63:0]         rdata_q, rdata_mux;
   logic                rd_first_q;
   logic                grant_wr, grant_rd, ok, unused_req;
   logic [63:0]         step, next_addr;

   function automatic logic [1:0] classify(input logic [63:0] addr, input logic [7:0] len,
                                           input logic [1:0] burst, input logic atomic);
      logic [1:0] err;
      err = RespOkay;
      if (atomic) err = RespSlvErr;
`ifdef ARIANE_AXI_SRAM_SLV_WRAP_EN
      if (burst == BurstWrap && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) err = RespSlvErr;
`else
      if (burst == BurstWrap || len != len) err = RespSlvErr;
`endif
      if ((addr >> (MemAddrWidth + 3)) != 64'd0) err = RespDecErr;
      return err;
   endfunction

   assign ok          = (err_q == RespOkay);
   assign unused_req  = ^axi_req_i;
   assign mem_addr_o  = addr_q[MemAddrWidth+2:3];
   assign mem_wdata_o = axi_req_i.w.data;
   assign mem_be_o    = axi_req_i.w.strb;
   assign step        = 64'd1 << size_q;
   // SRAM data is only valid in the first RD_RESP cycle; afterwards the captured copy is shown.
   assign rdata_mux   = rd_first_q ? (ok ? mem_rdata_i : 64'd0) : rdata_q;

`ifdef ARIANE_AXI_SRAM_SLV_WRAP_EN
   logic [63:0] wrap_mask;
   assign wrap_mask = (({56'd0, len_q} + 64'd1) << size_q) - 64'd1;
`endif

   always_comb begin
      next_addr = addr_q;
      case (burst_q)
         BurstIncr: next_addr = addr_q + step;
`ifdef ARIANE_AXI_SRAM_SLV_WRAP_EN
         BurstWrap: next_addr = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
`endif
         default: next_addr = addr_q;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      prefer_rd_d = prefer_rd_q;
      id_d        = id_q;
      addr_d      = addr_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      size_d      = size_q;
      burst_d     = burst_q;
      err_d       = err_q;
      grant_wr    = 1'b0;
      grant_rd    = 1'b0;
      axi_resp_o  = '0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      unique case (state_q)
         StIdle: begin
            grant_rd = axi_req_i.ar_valid && (!axi_req_i.aw_valid || prefer_rd_q);
            grant_wr = axi_req_i.aw_valid && !grant_rd;
            axi_resp_o.aw_ready = grant_wr;
            axi_resp_o.ar_ready = grant_rd;
            // Fairness only matters under contention, so the pointer moves only then.
            if (axi_req_i.aw_valid && axi_req_i.ar_valid) prefer_rd_d = grant_wr;
            cnt_d = 8'd0;
            if (grant_wr) begin
               id_d    = axi_req_i.aw.id;
               addr_d  = axi_req_i.aw.addr;
               len_d   = axi_req_i.aw.len;
               size_d  = axi_req_i.aw.size;
               burst_d = axi_req_i.aw.burst;
               err_d   = classify(axi_req_i.aw.addr, axi_req_i.aw.len, axi_req_i.aw.burst,
                                  axi_req_i.aw.atop != 6'd0);
               state_d = StWrData;
            end else if (grant_rd) begin
               id_d    = axi_req_i.ar.id;
               addr_d  = axi_req_i.ar.addr;
               len_d   = axi_req_i.ar.len;
               size_d  = axi_req_i.ar.size;
               burst_d = axi_req_i.ar.burst;
               err_d   = classify(axi_req_i.ar.addr, axi_req_i.ar.len, axi_req_i.ar.burst, 1'b0);
               state_d = StRdMem;
            end
         end
         StWrData: begin
            axi_resp_o.w_ready = 1'b1;
            if (axi_req_i.w_valid) begin
               mem_req_o = ok;
               mem_we_o  = ok;
               addr_d    = next_addr;
               cnt_d     = cnt_q + 8'd1;
               if (axi_req_i.w.last) state_d = StWrResp;
            end
         end
         StWrResp: begin
            axi_resp_o.b_valid = 1'b1;
            axi_resp_o.b.id    = id_q;
            axi_resp_o.b.resp  = err_q;
            if (axi_req_i.b_ready) state_d = StIdle;
         end
         StRdMem: begin
            mem_req_o = ok;
            state_d   = StRdResp;
         end
         StRdResp: begin
            axi_resp_o.r_valid = 1'b1;
            axi_resp_o.r.id    = id_q;
            axi_resp_o.r.data  = rdata_mux;
            axi_resp_o.r.resp  = err_q;
            axi_resp_o.r.last  = (cnt_q == len_q);
            if (axi_req_i.r_ready) begin
               if (cnt_q == len_q) begin
                  state_d = StIdle;
               end else begin
                  addr_d  = next_addr;
                  cnt_d   = cnt_q + 8'd1;
                  state_d = StRdMem;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         prefer_rd_q <= 1'b1;
         id_q        <= '0;
         addr_q      <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         size_q      <= '0;
         burst_q     <= '0;
         err_q       <= RespOkay;
         rdata_q     <= '0;
         rd_first_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         prefer_rd_q <= prefer_rd_d;
         id_q        <= id_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         size_q      <= size_d;
         burst_q     <= burst_d;
         err_q       <= err_d;
         rdata_q     <= rdata_mux;
         rd_first_q  <= (state_q == StRdMem);
      end
   end
endmodule

// File: tb/tb_ariane_axi_sram_slv.sv
// Directed plus randomized bench for ariane_axi_sram_slv against a word-array reference memory.
// Follows ARIANE_AXI_SRAM_SLV_WRAP_EN the same way as the design.

module tb_ariane_axi_sram_slv;
   localparam int unsigned MAW    = 14;
   localparam int unsigned NWords = 1 << MAW;

   logic clk = 1'b0;
   logic rst;
   ariane_axi::req_slv_t  req;
   ariane_axi::resp_slv_t resp;
   logic           mem_req, mem_we;
   logic [MAW-1:0] mem_addr;
   logic [63:0]    mem_wdata, mem_rdata;
   logic [7:0]     mem_be;

   logic [63:0] sram    [NWords];
   logic [63:0] ref_mem [NWords];
   logic [63:0] wd [16];
   logic [7:0]  ws [16];
   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   ariane_axi_sram_slv #(.MemAddrWidth(MAW)) dut (
      .clk_i(clk), .rst_i(rst), .axi_req_i(req), .axi_resp_o(resp),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata)
   );

   // SRAM: loaded from the reference image during reset; read data is garbage except one cycle
   // after a read strobe.
   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NWords; k++) sram[k] <= ref_mem[k];
         mem_rdata <= {$urandom, $urandom};
      end else if (mem_req && !mem_we) begin
         mem_rdata <= sram[mem_addr];
      end else begin
         if (mem_req) for (int b = 0; b < 8; b++) if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         mem_rdata <= {$urandom, $urandom};
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish, expected finish before 2ms");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      chk(tag, {63'd0, obs}, {63'd0, exp});
   endtask

   function automatic logic [1:0] ref_err(input logic [63:0] a, input int len,
                                          input logic [1:0] burst, input logic [5:0] atop);
      if (a >= (64'd1 << (MAW + 3))) return 2'b11;
`ifdef ARIANE_AXI_SRAM_SLV_WRAP_EN
      if (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 2'b10;
`else
      if (burst == 2'b10) return 2'b10;
`endif
      if (atop != 6'd0) return 2'b10;
      return 2'b00;
   endfunction

   // Address of beat i, straight from the burst definitions.
   function automatic logic [63:0] beat_addr(input logic [63:0] a, input int i, input logic [2:0] size,
                                             input int len, input logic [1:0] burst);
      logic [63:0] st, total, base;
      st = 64'd1 << size;
      if (burst == 2'b01) return a + 64'(i) * st;
      if (burst == 2'b10) begin
         total = 64'(len + 1) * st;
         base  = a - (a % total);
         return base + ((a - base + 64'(i) * st) % total);
      end
      return a;
   endfunction

   task automatic set_aw(input logic [4:0] id, input logic [63:0] a, input int len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [5:0] atop);
      req.aw = '0;
      req.aw.id = id; req.aw.addr = a; req.aw.len = 8'(len);
      req.aw.size = size; req.aw.burst = burst; req.aw.atop = atop;
      req.aw_valid = 1'b1;
   endtask

   task automatic set_ar(input logic [4:0] id, input logic [63:0] a, input int len,
                         input logic [2:0] size, input logic [1:0] burst);
      req.ar = '0;
      req.ar.id = id; req.ar.addr = a; req.ar.len = 8'(len);
      req.ar.size = size; req.ar.burst = burst;
      req.ar_valid = 1'b1;
   endtask

   task automatic handshake(input bit is_wr);
      int n;
      bit both;
      logic rdy;
      n = 0;
      both = req.aw_valid && req.ar_valid;
      @(negedge clk);
      rdy = is_wr ? resp.aw_ready : resp.ar_ready;
      while (!rdy && n < 50) begin
         @(posedge clk); #1; @(negedge clk);
         n++;
         rdy = is_wr ? resp.aw_ready : resp.ar_ready;
      end
      chk_b("addr_ready", rdy, 1'b1);
      if (both) begin
         chk("arb_first_cycle", 64'(n), 64'd0);
         chk_b("arb_exclusive", is_wr ? resp.ar_ready : resp.aw_ready, 1'b0);
      end
      @(posedge clk); #1;
      if (is_wr) req.aw_valid = 1'b0; else req.ar_valid = 1'b0;
   endtask

   task automatic do_write(input logic [4:0] id, input logic [63:0] a, input int len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [5:0] atop);
      logic [1:0] e;
      logic [63:0] ba;
      logic [MAW-1:0] w;
      e = ref_err(a, len, burst, atop);
      set_aw(id, a, len, size, burst, atop);
      handshake(1'b1);
      for (int i = 0; i <= len; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            req.w_valid = 1'b0;
            @(negedge clk);
            chk_b("w_gap_no_req", mem_req, 1'b0);
            chk_b("w_ready_gap", resp.w_ready, 1'b1);
            @(posedge clk); #1;
         end
         req.w = '0;
         req.w.data = wd[i]; req.w.strb = ws[i]; req.w.last = (i == len);
         req.w_valid = 1'b1;
         @(negedge clk);
         chk_b("w_ready", resp.w_ready, 1'b1);
         chk_b("wr_mem_req", mem_req, e == 2'b00);
         if (e == 2'b00) begin
            ba = beat_addr(a, i, size, len, burst);
            w  = ba[MAW+2:3];
            chk_b("wr_we", mem_we, 1'b1);
            chk("wr_addr", 64'(mem_addr), 64'(w));
            chk("wr_data", mem_wdata, wd[i]);
            chk("wr_be", 64'(mem_be), 64'(ws[i]));
            for (int b = 0; b < 8; b++) if (ws[i][b]) ref_mem[w][8*b +: 8] = wd[i][8*b +: 8];
         end
         @(posedge clk); #1;
      end
      req.w_valid = 1'b0;
      req.w.last  = 1'b0;
      @(negedge clk);
      chk_b("b_valid", resp.b_valid, 1'b1);
      chk("b_resp", 64'(resp.b.resp), 64'(e));
      chk("b_id", 64'(resp.b.id), 64'(id));
      repeat ($urandom_range(0, 2)) begin
         @(posedge clk); #1; @(negedge clk);
         chk_b("b_valid_hold", resp.b_valid, 1'b1);
      end
      req.b_ready = 1'b1;
      @(posedge clk); #1;
      req.b_ready = 1'b0;
   endtask

   task automatic do_read(input logic [4:0] id, input logic [63:0] a, input int len,
                          input logic [2:0] size, input logic [1:0] burst, input bit bp);
      logic [1:0] e;
      logic [63:0] ba, exp;
      logic [MAW-1:0] w;
      e = ref_err(a, len, burst, 6'd0);
      set_ar(id, a, len, size, burst);
      handshake(1'b0);
      for (int i = 0; i <= len; i++) begin
         ba  = beat_addr(a, i, size, len, burst);
         w   = ba[MAW+2:3];
         exp = (e == 2'b00) ? ref_mem[w] : 64'd0;
         @(negedge clk);
         chk_b("rd_mem_req", mem_req, e == 2'b00);
         chk_b("r_valid_early", resp.r_valid, 1'b0);
         if (e == 2'b00) begin
            chk_b("rd_we", mem_we, 1'b0);
            chk("rd_addr", 64'(mem_addr), 64'(w));
         end
         @(posedge clk); #1;
         req.r_ready = 1'b0;
         repeat (bp ? $urandom_range(0, 2) : 0) begin
            @(negedge clk);
            chk_b("r_valid_stall", resp.r_valid, 1'b1);
            chk("r_data_stall", resp.r.data, exp);
            @(posedge clk); #1;
         end
         req.r_ready = 1'b1;
         @(negedge clk);
         chk_b("r_valid", resp.r_valid, 1'b1);
         chk("r_data", resp.r.data, exp);
         chk("r_resp", 64'(resp.r.resp), 64'(e));
         chk_b("r_last", resp.r.last, i == len);
         chk("r_id", 64'(resp.r.id), 64'(id));
         @(posedge clk); #1;
         req.r_ready = 1'b0;
      end
   endtask

   task automatic rand_wdata();
      for (int i = 0; i < 16; i++) begin
         wd[i] = {$urandom, $urandom};
         ws[i] = 8'($urandom);
      end
   endtask

   initial begin
      logic [63:0] a;
      int len;
      logic [1:0] burst;
      for (int k = 0; k < NWords; k++) ref_mem[k] = {$urandom, $urandom};
      req = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk_b("rst_aw_ready", resp.aw_ready, 1'b0);
      chk_b("rst_w_ready", resp.w_ready, 1'b0);
      chk_b("rst_b_valid", resp.b_valid, 1'b0);
      chk_b("rst_r_valid", resp.r_valid, 1'b0);
      chk_b("rst_mem_req", mem_req, 1'b0);
      chk("rst_r_data", resp.r.data, 64'd0);
      chk("rst_ids", 64'({resp.r.id, resp.b.id, resp.r.resp, resp.b.resp}), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Single write, then read back.
      wd[0] = 64'hDEADBEEF_01234567; ws[0] = 8'hFF;
      do_write(5'd5, 64'h40, 0, 3'd3, 2'b01, 6'd0);
      chk("word8_model", ref_mem[8], 64'hDEADBEEF_01234567);
      do_read(5'd5, 64'h40, 0, 3'd3, 2'b01, 1'b0);

      // INCR read with backpressure.
      do_read(5'd9, 64'h100, 3, 3'd3, 2'b01, 1'b1);

      // Narrow write into word 2, then read the word back.
      wd[0] = {$urandom, $urandom}; ws[0] = 8'h08;
      wd[1] = {$urandom, $urandom}; ws[1] = 8'h10;
      do_write(5'd3, 64'h13, 1, 3'd0, 2'b01, 6'd0);
      do_read(5'd3, 64'h10, 0, 3'd3, 2'b01, 1'b0);

      // Out of range.
      rand_wdata();
      do_write(5'd7, 64'h2_0000, 2, 3'd3, 2'b01, 6'd0);
      do_read(5'd7, 64'h2_0000, 2, 3'd3, 2'b01, 1'b1);

      // WRAP bursts.
      do_read(5'd11, 64'h38, 3, 3'd3, 2'b10, 1'b0);
      rand_wdata();
      do_write(5'd12, 64'h38, 3, 3'd3, 2'b10, 6'd0);
      do_read(5'd13, 64'h20, 3, 3'd3, 2'b01, 1'b0);

      // Reset in the middle of a write burst.
      set_aw(5'd1, 64'h80, 3, 3'd3, 2'b01, 6'd0);
      handshake(1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk_b("midrst_w_ready", resp.w_ready, 1'b0);
      chk_b("midrst_b_valid", resp.b_valid, 1'b0);
      chk_b("midrst_mem_req", mem_req, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Simultaneous requests: read wins first after reset, write wins the next contention.
      rand_wdata();
      set_aw(5'd20, 64'h300, 1, 3'd3, 2'b01, 6'd0);
      do_read(5'd21, 64'h300, 1, 3'd3, 2'b01, 1'b0);
      do_write(5'd20, 64'h300, 1, 3'd3, 2'b01, 6'd0);
      set_ar(5'd22, 64'h300, 1, 3'd3, 2'b01);
      do_write(5'd23, 64'h308, 0, 3'd3, 2'b01, 6'd0);
      do_read(5'd22, 64'h300, 1, 3'd3, 2'b01, 1'b0);

      // Random traffic.
      for (int t = 0; t < 40; t++) begin
         a = 64'($urandom_range(0, (1 << (MAW + 3)) - 1));
         if ($urandom_range(0, 7) == 0) a[40] = 1'b1;
         burst = 2'($urandom_range(0, 2));
         len = $urandom_range(0, 7);
         if (burst == 2'b10 && $urandom_range(0, 3) != 0) len = (2 << $urandom_range(0, 2)) - 1;
         rand_wdata();
         if ($urandom_range(0, 1) == 0)
            do_write(5'($urandom), a, len, 3'($urandom_range(0, 3)), burst,
                     ($urandom_range(0, 7) == 0) ? 6'h21 : 6'd0);
         else
            do_read(5'($urandom), a, len, 3'($urandom_range(0, 3)), burst, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/ariane_axi_sram_slv.md
# ariane_axi_sram_slv

AXI4 subordinate that terminates the slave-side request/response structs (`ariane_axi::req_slv_t` / `ariane_axi::resp_slv_t`) and converts bursts into single-port, 64-bit-wide SRAM accesses. It sits behind the SoC crossbar as the responder for on-chip scratchpad and boot RAM. It serves one transaction at a time, read or write, with round-robin arbitration between AW and AR.

## Interface
- `MemAddrWidth`, default 14: word-index width; reachable region is 2^MemAddrWidth × 8 bytes from address 0 (crossbar strips the base).
- `clk_i` in, 1: clock.
- `rst_i` in, 1: synchronous, active-high reset.
- `axi_req_i` in, `ariane_axi::req_slv_t`: AW/W/AR channels, B/R ready.
- `axi_resp_o` out, `ariane_axi::resp_slv_t`: B/R channels, AW/W/AR ready.
- `mem_req_o` out, 1: SRAM access strobe.
- `mem_we_o` out, 1: write enable, qualified by `mem_req_o`.
- `mem_addr_o` out, MemAddrWidth: word index, `addr[MemAddrWidth+2:3]`.
- `mem_wdata_o` out, 64: write data, equal to `w.data`.
- `mem_be_o` out, 8: byte enables, equal to `w.strb`.
- `mem_rdata_i` in, 64: read data, valid exactly 1 cycle after a read `mem_req_o`.

## Operation
- States: IDLE, WR_DATA, WR_RESP, RD_MEM, RD_RESP.
- IDLE: arbitration between requests.
  - If only AW is valid, grant write; if only AR is valid, grant read.
  - If both are valid, grant the side not served last (round-robin bit; after reset it favours read).
  - Granted channel's ready is high in that cycle.
  - Latch id, addr, len, size, burst, atop, beat counter = 0, and error class.
- Error class, evaluated at the address handshake, applies to every beat:
  - Address bits above bit MemAddrWidth+2 nonzero → DECERR.
  - Else `burst`=WRAP with `len` ∉ {1,3,7,15} → SLVERR.
  - Else write with `atop`≠0 → SLVERR. No R beats are generated for atomics.
  - Else OKAY.
- Any error: no SRAM access. W beats are still consumed. R beats carry data 0.
- WR_DATA:
  - `w_ready`=1.
  - Each W handshake with OKAY drives `mem_req_o`=`mem_we_o`=1 combinationally in the same cycle.
  - Then advance the address and increment the beat counter.
  - Handshake with `w.last`=1 → WR_RESP. `w.last` is trusted; the beat count is not checked.
- WR_RESP: `b_valid`=1, `b.id`=latched id, `b.resp`=error class. Handshake → IDLE.
- RD_MEM: one cycle. Drives `mem_req_o`=1, `mem_we_o`=0 if OKAY. Then → RD_RESP.
- RD_RESP:
  - `r_valid`=1, `r.data` = `mem_rdata_i` captured into a register, `r.last` = (counter==len).
  - Handshake on a non-last beat → advance address, RD_MEM.
  - Handshake on the last beat → IDLE.
- Address advance uses step = 2^size bytes.
  - FIXED: unchanged.
  - INCR: addr + step, 64-bit wrap-around.
  - WRAP: addr = (addr & ~mask) | ((addr + step) & mask), where mask = (len+1)·step − 1.
- `user` outputs are 0. `b.id`/`r.id` echo the latched id.

## Timing
- Reset: all state is synchronous.
  - State = IDLE, round-robin bit = read.
  - `aw_ready`, `ar_ready`, `w_ready`, `b_valid`, `r_valid`, `mem_req_o`, `mem_we_o` = 0.
  - `r.data`, `r.resp`, `b.resp`, ids = 0.
- Reset mid-burst aborts the burst immediately. No B/R is completed; the master side must be reset together with this block.
- Write timing:
  - AW handshake at cycle T; `w_ready` from T+1; one beat per cycle.
  - Last W handshake at cycle L gives `b_valid` at L+1.
- Read timing:
  - AR handshake at T; mem read at T+1; `r_valid` at T+2.
  - R handshake at cycle H gives the next mem read at H+1 and `r_valid` at H+2. Throughput is 1 beat / 2 cycles.
- Valid/data are held stable until the handshake.
- Returning to IDLE costs one cycle: a new AW/AR is accepted no earlier than the cycle after a B/last-R handshake.
- `aw_ready`/`ar_ready` may depend combinationally on the valids. `w_ready` is state-only.

## Configuration
- `ARIANE_AXI_SRAM_SLV_WRAP_EN`:
  - Defined: WRAP bursts are supported as above.
  - Undefined: every WRAP burst is classified SLVERR. No SRAM access; W beats are consumed, R beats return data 0. The wrap-mask logic is not synthesised.

## Test plan
- Single write, then read:
  - Stimulus: AW addr 0x40, len 0, size 3, id 5; W data 0xDEADBEEF_01234567, strb 0xFF, last 1.
  - Required: mem write at word 8; B resp OKAY, id 5 at L+1.
  - Then AR to the same address returns that data, resp OKAY, last 1, `r_valid` at T+2.
- INCR burst with backpressure:
  - Stimulus: AR addr 0x100, len 3, size 3, `r_ready` toggling.
  - Required: mem words 0x20–0x23 are read in order; `r.last` only on beat 3; data stable while stalled.
- Narrow write:
  - Stimulus: AW addr 0x13, size 0, INCR, len 1; strb 0x08 then 0x10.
  - Required: mem word 2 is written twice with the master's strobes; B OKAY.
- Out of range, MemAddrWidth=14:
  - Stimulus: AW addr 0x2_0000, len 2.
  - Required: three W beats accepted; `mem_req_o` never asserted; B DECERR.
  - AR to the same address returns three beats of data 0, DECERR.
- Simultaneous AW and AR after reset:
  - Required: read granted first, then write; the next simultaneous pair grants write first.
- WRAP burst:
  - Stimulus: AR addr 0x38, len 3, size 3.
  - Required with the macro defined: words 7, 4, 5, 6, all OKAY.
  - Required with the macro undefined: four beats of SLVERR, data 0, no mem access.
